// File: rtl/axis_sched_pkg.sv
// Shared definitions for the weighted round-robin stream scheduler.
package axis_sched_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } sched_state_e;

  localparam int DEFAULT_WEIGHT = 1;

  function automatic int idx_width(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

endpackage

// File: rtl/axis_wrr_sched_if.sv
// Request/grant bundle between the scheduler and the stream mux it steers.
interface axis_wrr_sched_if
  import axis_sched_pkg::*;
#(
  parameter int PORTS = 4
);
  localparam int IDX_W = idx_width(PORTS);

  logic [PORTS-1:0] request;
  logic [PORTS-1:0] acknowledge;
  logic [PORTS-1:0] grant;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_encoded;
  logic             busy;

  modport master (
    input  request, acknowledge,
    output grant, grant_valid, grant_encoded, busy
  );

  modport slave (
    output request, acknowledge,
    input  grant, grant_valid, grant_encoded, busy
  );

endinterface

// File: rtl/axis_wrr_sched_rr_pick.sv
// Rotating priority encoder: first set request at or after start_i, wrapping.
module rr_pick
  import axis_sched_pkg::*;
#(
  parameter int PORTS = 4,
  parameter int IDX_W = idx_width(PORTS)
) (
  input  logic [PORTS-1:0] req_i,
  input  logic [IDX_W-1:0] start_i,
  output logic [PORTS-1:0] onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  always_comb begin
    int p;
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    p        = 0;
    for (int k = 0; k < PORTS; k++) begin
      p = (int'(start_i) + k) % PORTS;
      if (!valid_o && req_i[p]) begin
        valid_o     = 1'b1;
        idx_o       = IDX_W'(p);
        onehot_o[p] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_wrr_sched.sv
// Weighted round-robin packet scheduler: grants one requester per packet and
// lets a port keep its turn for up to <weight> packets.
module axis_wrr_sched
  import axis_sched_pkg::*;
#(
  parameter int PORTS        = 4,
  parameter int WEIGHT_WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [PORTS*WEIGHT_WIDTH-1:0]   weight,
  input  logic                            weight_load,
  axis_wrr_sched_if.master                bus
);

  localparam int IDX_W = idx_width(PORTS);

  sched_state_e                           state_q;
  logic [PORTS-1:0]                       grant_q;
  logic [IDX_W-1:0]                       grant_enc_q;
  logic                                   grant_valid_q;
  logic                                   busy_q;
  logic [WEIGHT_WIDTH-1:0]                credit_q;
  logic [IDX_W-1:0]                       last_q;
  logic [PORTS-1:0][WEIGHT_WIDTH-1:0]     weight_q;

  logic [IDX_W-1:0]                       start_idx;
  logic [PORTS-1:0]                       pick_onehot;
  logic [IDX_W-1:0]                       pick_idx;
  logic                                   pick_valid;
  logic                                   regrant;
  logic [WEIGHT_WIDTH-1:0]                pick_w;
  logic [WEIGHT_WIDTH-1:0]                credit_d;
  logic [PORTS-1:0]                       last_onehot;

  assign start_idx   = (last_q == IDX_W'(PORTS-1)) ? '0 : last_q + 1'b1;
  assign regrant     = (credit_q != '0) && bus.request[last_q];
  assign last_onehot = PORTS'(1) << last_q;
  assign pick_w      = weight_q[pick_idx];
  // A zero weight would starve the port, so it still earns one packet.
  assign credit_d    = (pick_w == '0) ? WEIGHT_WIDTH'(DEFAULT_WEIGHT) : pick_w;

  rr_pick #(.PORTS(PORTS), .IDX_W(IDX_W)) u_pick (
    .req_i    (bus.request),
    .start_i  (start_idx),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_enc_q   <= '0;
      grant_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      credit_q      <= '0;
      last_q        <= IDX_W'(PORTS-1);
      for (int i = 0; i < PORTS; i++) weight_q[i] <= WEIGHT_WIDTH'(DEFAULT_WEIGHT);
    end else begin
      // Non-blocking update means a coincident credit load sees the old weight.
      if (weight_load)
        for (int i = 0; i < PORTS; i++) weight_q[i] <= weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      case (state_q)
        IDLE: begin
          if (regrant) begin
            state_q       <= ACTIVE;
            grant_q       <= last_onehot;
            grant_enc_q   <= last_q;
            grant_valid_q <= 1'b1;
            busy_q        <= 1'b1;
          end else if (pick_valid) begin
            state_q       <= ACTIVE;
            grant_q       <= pick_onehot;
            grant_enc_q   <= pick_idx;
            grant_valid_q <= 1'b1;
            busy_q        <= 1'b1;
            last_q        <= pick_idx;
            credit_q      <= credit_d;
          end
        end
        ACTIVE: begin
          if (bus.acknowledge[grant_enc_q]) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_enc_q   <= '0;
            grant_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            credit_q      <= (credit_q == '0) ? '0 : credit_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant         = grant_q;
  assign bus.grant_encoded = grant_enc_q;
  assign bus.grant_valid   = grant_valid_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_axis_wrr_sched.sv
// Directed bench for axis_wrr_sched: packet-by-packet grant order checks.
module tb_axis_wrr_sched;

  logic        clk;
  logic        rst;
  logic [15:0] weight;
  logic        weight_load;
  int          tests;
  int          fails;

  axis_wrr_sched_if #(.PORTS(4)) bus ();

  axis_wrr_sched #(.PORTS(4), .WEIGHT_WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .weight      (weight),
    .weight_load (weight_load),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst             = 1'b1;
    bus.request     = '0;
    bus.acknowledge = '0;
    weight          = '0;
    weight_load     = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic load_weights(input logic [15:0] w);
    weight      = w;
    weight_load = 1'b1;
    step();
    weight_load = 1'b0;
  endtask

  // Serves n packets; seq holds the expected port per packet, one nibble each.
  task automatic serve(input string name, input int n, input int beats, input logic [63:0] seq);
    for (int i = 0; i < n; i++) begin
      int         cnt;
      logic [1:0] exp;
      cnt = 0;
      exp = seq[i*4 +: 2];
      while (!bus.grant_valid && cnt < 20) begin
        step();
        cnt++;
      end
      tests++;
      if (!bus.grant_valid) begin
        $display("FAIL %s_timeout pkt %0d: no grant_valid within 20 cycles", name, i);
        fails++;
        return;
      end
      tests++;
      if (cnt != 1) begin
        $display("FAIL %s_latency pkt %0d: got %0d cycles, want 1", name, i, cnt);
        fails++;
      end
      tests++;
      if (bus.grant_encoded !== exp) begin
        $display("FAIL %s_enc pkt %0d: got %0d, want %0d", name, i, bus.grant_encoded, exp);
        fails++;
      end
      tests++;
      if (bus.grant !== (4'b0001 << exp)) begin
        $display("FAIL %s_onehot pkt %0d: got %b, want %b", name, i, bus.grant, 4'b0001 << exp);
        fails++;
      end
      repeat (beats - 1) step();
      bus.acknowledge = 4'b0001 << exp;
      step();
      bus.acknowledge = '0;
      tests++;
      if (bus.grant_valid !== 1'b0 || bus.busy !== 1'b0) begin
        $display("FAIL %s_bubble pkt %0d: grant_valid=%b busy=%b, want 0 0", name, i,
                 bus.grant_valid, bus.busy);
        fails++;
      end
    end
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    bus.request     = 4'b1111;
    bus.acknowledge = '0;
    weight          = '0;
    weight_load     = 1'b0;
    step();
    tests++;
    if (bus.grant !== 4'b0000 || bus.grant_valid !== 1'b0 ||
        bus.grant_encoded !== 2'd0 || bus.busy !== 1'b0) begin
      $display("FAIL reset_outputs: grant=%b gv=%b enc=%0d busy=%b, want all 0",
               bus.grant, bus.grant_valid, bus.grant_encoded, bus.busy);
      fails++;
    end
    rst         = 1'b0;
    bus.request = '0;
    bus.acknowledge = 4'b1111;
    repeat (3) step();
    bus.acknowledge = '0;
    tests++;
    if (bus.grant !== 4'b0000 || bus.grant_valid !== 1'b0 || bus.busy !== 1'b0) begin
      $display("FAIL idle_no_request: grant=%b gv=%b busy=%b, want 0 0 0",
               bus.grant, bus.grant_valid, bus.busy);
      fails++;
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    bus.request = 4'b1111;
    serve("rr", 5, 3, 64'h03210);
    bus.request = '0;
  endtask

  task automatic test_weighted();
    apply_reset();
    load_weights(16'h1113);
    bus.request = 4'b1111;
    serve("wrr", 9, 1, 64'h000321000);
    bus.request = '0;
  endtask

  task automatic test_zero_weight();
    apply_reset();
    load_weights(16'h0000);
    bus.request = 4'b0100;
    serve("zero_w", 3, 2, 64'h222);
    bus.request = '0;
  endtask

  task automatic test_hold();
    apply_reset();
    bus.request = 4'b0010;
    step();
    tests++;
    if (bus.grant !== 4'b0010 || bus.grant_encoded !== 2'd1) begin
      $display("FAIL hold_first: grant=%b enc=%0d, want 0010 1", bus.grant, bus.grant_encoded);
      fails++;
    end
    bus.request     = '0;
    bus.acknowledge = 4'b1000;
    step();
    bus.acknowledge = '0;
    tests++;
    if (bus.grant !== 4'b0010 || bus.grant_valid !== 1'b1) begin
      $display("FAIL hold_spurious_ack: grant=%b gv=%b, want 0010 1", bus.grant, bus.grant_valid);
      fails++;
    end
    step();
    tests++;
    if (bus.grant !== 4'b0010 || bus.busy !== 1'b1) begin
      $display("FAIL hold_req_drop: grant=%b busy=%b, want 0010 1", bus.grant, bus.busy);
      fails++;
    end
    bus.request     = 4'b0010;
    bus.acknowledge = 4'b0010;
    step();
    bus.acknowledge = '0;
    bus.request     = '0;
    tests++;
    if (bus.grant !== 4'b0000 || bus.grant_valid !== 1'b0) begin
      $display("FAIL hold_release: grant=%b gv=%b, want 0000 0", bus.grant, bus.grant_valid);
      fails++;
    end
  endtask

  task automatic test_weight_update();
    apply_reset();
    load_weights(16'h1112);
    // Load coincides with the credit load: port 0 must get the old weight 2.
    bus.request = 4'b0011;
    load_weights(16'h1119);
    tests++;
    if (bus.grant !== 4'b0001 || bus.grant_valid !== 1'b1) begin
      $display("FAIL wupd_first: grant=%b gv=%b, want 0001 1", bus.grant, bus.grant_valid);
      fails++;
    end
    load_weights(16'h1115);
    tests++;
    if (bus.grant !== 4'b0001 || bus.grant_valid !== 1'b1) begin
      $display("FAIL wupd_hold: grant=%b gv=%b, want 0001 1", bus.grant, bus.grant_valid);
      fails++;
    end
    bus.acknowledge = 4'b0001;
    step();
    bus.acknowledge = '0;
    tests++;
    if (bus.grant_valid !== 1'b0) begin
      $display("FAIL wupd_bubble: gv=%b, want 0", bus.grant_valid);
      fails++;
    end
    serve("wupd", 8, 1, 64'h10000010);
    bus.request = '0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.request = 4'b1000;
    step();
    tests++;
    if (bus.grant_encoded !== 2'd3 || bus.grant !== 4'b1000) begin
      $display("FAIL rmid_grant3: enc=%0d grant=%b, want 3 1000", bus.grant_encoded, bus.grant);
      fails++;
    end
    step();
    bus.request = 4'b1111;
    rst         = 1'b1;
    step();
    tests++;
    if (bus.grant !== 4'b0000 || bus.grant_valid !== 1'b0 || bus.busy !== 1'b0) begin
      $display("FAIL rmid_drop: grant=%b gv=%b busy=%b, want 0000 0 0",
               bus.grant, bus.grant_valid, bus.busy);
      fails++;
    end
    rst = 1'b0;
    step();
    tests++;
    if (bus.grant_encoded !== 2'd0 || bus.grant !== 4'b0001 || bus.grant_valid !== 1'b1) begin
      $display("FAIL rmid_restart: enc=%0d grant=%b gv=%b, want 0 0001 1",
               bus.grant_encoded, bus.grant, bus.grant_valid);
      fails++;
    end
    bus.request = '0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_round_robin();
    test_weighted();
    test_zero_weight();
    test_hold();
    test_weight_update();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
